// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: Start accepted in IDLE only, result and Done 34 cycles later.
// Define MDU_DIVZERO_EN to add DivZero and a 2-cycle early-out for divide by zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             Clock,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef MDU_DIVZERO_EN
  ,
  output logic             DivZero
`endif
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_start_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shrem;
  logic [WIDTH+1:0]   w_diff;
  logic               w_sub_ok;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_neg_res;

  assign w_start_signed = ~Op[0];
  assign w_a_neg        = w_start_signed & OperandA[WIDTH-1];
  assign w_b_neg        = w_start_signed & OperandB[WIDTH-1];
  assign w_mag_a        = w_a_neg ? -OperandA : OperandA;
  assign w_mag_b        = w_b_neg ? -OperandB : OperandB;

  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, dividend/quotient bits}, shifted left each step.
  assign w_shrem    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = {1'b0, w_shrem} - {2'b00, r_opnd};
  assign w_sub_ok   = (w_diff[WIDTH+1:WIDTH] == 2'b00);
  assign w_div_next = w_sub_ok ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                               : {r_acc[2*WIDTH-2:0], 1'b0};

  assign w_neg_res  = r_sign_a ^ r_sign_b;
  assign w_prod_fix = w_neg_res ? -r_acc : r_acc;
  assign w_quot_fix = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_res_hi   = r_op[1] ? w_rem_fix  : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo   = r_op[1] ? w_quot_fix : w_prod_fix[WIDTH-1:0];

`ifdef MDU_DIVZERO_EN
  logic r_dz_pend;
  logic r_divzero;
  logic w_dz_start;

  assign w_dz_start = Op[1] & (OperandB == {WIDTH{1'b0}});
  assign DivZero    = r_divzero;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_dz_pend <= 1'b0;
      r_divzero <= 1'b0;
    end else if (r_state == S_IDLE && Start) begin
      r_dz_pend <= w_dz_start;
      r_divzero <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_divzero <= r_dz_pend;
    end
  end
`else
  logic w_dz_start;
  assign w_dz_start = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 2'b00;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (HiWrite) r_hi <= WriteData;
          if (LoWrite) r_lo <= WriteData;
          if (Start) begin
            r_op     <= Op;
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_cnt    <= '0;
            if (w_dz_start) begin
              // Divide by zero skips RUN: preload what the restoring loop would produce.
              r_opnd  <= '0;
              r_acc   <= {w_mag_a, {WIDTH{1'b1}}};
              r_state <= S_FIX;
            end else if (Op[1]) begin
              r_opnd  <= w_mag_b;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
              r_state <= S_RUN;
            end else begin
              r_opnd  <= w_mag_a;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic results, ignore-while-busy, abort, divide by zero.
module tb_mult_div_unit;
  logic        Clock = 1'b0;
  logic        Reset_L = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OperandA = '0;
  logic [31:0] OperandB = '0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;
`ifdef MDU_DIVZERO_EN
  logic        DivZero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int          done_first, done_cnt, busy_cnt, busy_last;
  logic [31:0] hi_at_done, lo_at_done, hi_mid, lo_mid;
  logic        dz_at_done;

  always #5 Clock = ~Clock;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clock(Clock), .Reset_L(Reset_L), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
`ifdef MDU_DIVZERO_EN
    , .DivZero(DivZero)
`endif
  );

  // Issues one operation and observes a 40-cycle window; inj>0 pokes Start/MTHI/MTLO at that cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clock); #1;
    Start = 1'b0; OperandA = ~a; OperandB = b + 32'h1234;
    done_first = 0; done_cnt = 0; busy_cnt = 0; busy_last = 0;
    hi_at_done = 'x; lo_at_done = 'x; hi_mid = 'x; lo_mid = 'x; dz_at_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Busy) begin busy_cnt++; busy_last = c; end
      if (Done) begin
        done_cnt++;
        if (done_first == 0) begin
          done_first = c; hi_at_done = Hi; lo_at_done = Lo;
`ifdef MDU_DIVZERO_EN
          dz_at_done = DivZero;
`endif
        end
      end
      if (c == 20) begin hi_mid = Hi; lo_mid = Lo; end
      if (inj != 0 && c == inj) begin
        Start = 1'b1; Op = 2'b01; OperandA = 32'd7; OperandB = 32'd9;
        HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset();
    #2 Reset_L = 1'b0;
    #1;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", Busy); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", Done); end
    n_tests++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", Hi); end
    n_tests++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", Lo); end
    repeat (2) @(posedge Clock);
    #1 Reset_L = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_mthi_mtlo();
    HiWrite = 1'b1; WriteData = 32'h1234_5678;
    @(posedge Clock); #1;
    HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'h9ABC_DEF0;
    @(posedge Clock); #1;
    LoWrite = 1'b0;
    n_tests++; if (Hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi got %h want 12345678", Hi); end
    n_tests++; if (Lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo got %h want 9abcdef0", Lo); end
  endtask

  task automatic test_multu();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    n_tests++; if (done_first !== 34) begin n_fail++; $display("FAIL multu_done_cycle got %0d want 34", done_first); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL multu_done_pulses got %0d want 1", done_cnt); end
    n_tests++; if (busy_cnt !== 33) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 33", busy_cnt); end
    n_tests++; if (busy_last !== 33) begin n_fail++; $display("FAIL multu_busy_last got %0d want 33", busy_last); end
    n_tests++; if (hi_mid !== 32'h1234_5678) begin n_fail++; $display("FAIL multu_hi_hold got %h want 12345678", hi_mid); end
    n_tests++; if (lo_mid !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL multu_lo_hold got %h want 9abcdef0", lo_mid); end
    n_tests++; if (hi_at_done !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi_at_done); end
    n_tests++; if (lo_at_done !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo_at_done); end
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    n_tests++; if (done_first !== 34) begin n_fail++; $display("FAIL mult_done_cycle got %0d want 34", done_first); end
    n_tests++; if (hi_at_done !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi_at_done); end
    n_tests++; if (lo_at_done !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", lo_at_done); end
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    n_tests++; if (done_first !== 34) begin n_fail++; $display("FAIL div_done_cycle got %0d want 34", done_first); end
    n_tests++; if (lo_at_done !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo_at_done); end
    n_tests++; if (hi_at_done !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi_at_done); end
  endtask

  task automatic test_divu();
    run_op(2'b11, 32'd100, 32'd7, 0);
    n_tests++; if (lo_at_done !== 32'h0000_000E) begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", lo_at_done); end
    n_tests++; if (hi_at_done !== 32'h0000_0002) begin n_fail++; $display("FAIL divu_hi got %h want 00000002", hi_at_done); end
  endtask

  task automatic test_div_overflow();
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    n_tests++; if (lo_at_done !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", lo_at_done); end
    n_tests++; if (hi_at_done !== 32'h0000_0000) begin n_fail++; $display("FAIL divovf_hi got %h want 00000000", hi_at_done); end
  endtask

  task automatic test_busy_ignore();
    run_op(2'b01, 32'd3, 32'd5, 5);
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d want 1", done_cnt); end
    n_tests++; if (done_first !== 34) begin n_fail++; $display("FAIL ignore_done_cycle got %0d want 34", done_first); end
    n_tests++; if (lo_at_done !== 32'd15) begin n_fail++; $display("FAIL ignore_lo got %h want 0000000f", lo_at_done); end
    n_tests++; if (hi_at_done !== 32'd0) begin n_fail++; $display("FAIL ignore_hi got %h want 00000000", hi_at_done); end
    n_tests++; if (Hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi_after got %h want 00000000", Hi); end
  endtask

  task automatic test_abort();
    int dn;
    int bz;
    HiWrite = 1'b1; WriteData = 32'hCAFE_0001;
    @(posedge Clock); #1;
    HiWrite = 1'b0;
    Start = 1'b1; Op = 2'b01; OperandA = 32'd3; OperandB = 32'd5;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge Clock); #1; end
    Reset_L = 1'b0;
    #1;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", Busy); end
    n_tests++; if (Hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi got %h want 0", Hi); end
    n_tests++; if (Lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo got %h want 0", Lo); end
    #1 Reset_L = 1'b1;
    dn = 0; bz = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clock); #1;
      if (Done) dn++;
      if (Busy) bz++;
    end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", dn); end
    n_tests++; if (bz !== 0) begin n_fail++; $display("FAIL abort_no_busy got %0d cycles want 0", bz); end
    n_tests++; if (Lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo_after got %h want 0", Lo); end
  endtask

  task automatic test_divzero();
    int exp_cyc;
`ifdef MDU_DIVZERO_EN
    exp_cyc = 2;
`else
    exp_cyc = 34;
`endif
    run_op(2'b11, 32'd5, 32'd0, 0);
    n_tests++; if (done_first !== exp_cyc) begin n_fail++; $display("FAIL divzero_u_cycle got %0d want %0d", done_first, exp_cyc); end
    n_tests++; if (busy_cnt !== exp_cyc - 1) begin n_fail++; $display("FAIL divzero_u_busy got %0d want %0d", busy_cnt, exp_cyc - 1); end
    n_tests++; if (lo_at_done !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_u_lo got %h want ffffffff", lo_at_done); end
    n_tests++; if (hi_at_done !== 32'd5) begin n_fail++; $display("FAIL divzero_u_hi got %h want 00000005", hi_at_done); end
`ifdef MDU_DIVZERO_EN
    n_tests++; if (dz_at_done !== 1'b1) begin n_fail++; $display("FAIL divzero_flag got %0b want 1", dz_at_done); end
    n_tests++; if (DivZero !== 1'b1) begin n_fail++; $display("FAIL divzero_flag_hold got %0b want 1", DivZero); end
`endif
    run_op(2'b10, 32'hFFFF_FFF8, 32'd0, 0);
    n_tests++; if (done_first !== exp_cyc) begin n_fail++; $display("FAIL divzero_s_cycle got %0d want %0d", done_first, exp_cyc); end
    n_tests++; if (lo_at_done !== 32'h0000_0001) begin n_fail++; $display("FAIL divzero_s_lo got %h want 00000001", lo_at_done); end
    n_tests++; if (hi_at_done !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL divzero_s_hi got %h want fffffff8", hi_at_done); end
`ifdef MDU_DIVZERO_EN
    run_op(2'b11, 32'd100, 32'd7, 0);
    n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL divzero_clear got %0b want 0", DivZero); end
`endif
  endtask

  task automatic test_back_to_back();
    int c;
    Start = 1'b1; Op = 2'b01; OperandA = 32'd2; OperandB = 32'd3;
    @(posedge Clock); #1;
    Start = 1'b0;
    c = 1;
    while (!Done && c < 60) begin @(posedge Clock); #1; c++; end
    n_tests++; if (c !== 34) begin n_fail++; $display("FAIL b2b_first_cycle got %0d want 34", c); end
    n_tests++; if (Lo !== 32'd6) begin n_fail++; $display("FAIL b2b_first_lo got %h want 00000006", Lo); end
    Start = 1'b1; Op = 2'b11; OperandA = 32'd100; OperandB = 32'd7;
    @(posedge Clock); #1;
    Start = 1'b0;
    n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %0b want 1", Busy); end
    c = 1;
    while (!Done && c < 60) begin @(posedge Clock); #1; c++; end
    n_tests++; if (c !== 34) begin n_fail++; $display("FAIL b2b_second_cycle got %0d want 34", c); end
    n_tests++; if (Lo !== 32'h0000_000E) begin n_fail++; $display("FAIL b2b_second_lo got %h want 0000000e", Lo); end
    n_tests++; if (Hi !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_second_hi got %h want 00000002", Hi); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_multu();
    test_mult();
    test_div();
    test_divu();
    test_div_overflow();
    test_busy_ignore();
    test_abort();
    test_divzero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
